// File: rtl/lp_piped_int_addsub.sv
// rtl/lp_piped_int_addsub.sv - pipelined SIMD integer add/sub with tagged, bubble-collapsing slots
// The result is computed once at insertion; later slots only carry it toward the output slot.
module lp_piped_int_addsub #(
  parameter int WIDTH       = 32,
  parameter int LANES       = 1,
  parameter int SAT_MODE    = 0,
  parameter int ID_WIDTH    = 8,
  parameter int STAGES      = 4,
  parameter int OP_ISO_MODE = 1,
  localparam int CW         = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 op,
  input  logic                 launch,
  input  logic [ID_WIDTH-1:0]  launch_id,
  input  logic                 flush,
  input  logic                 accept_n,
  output logic [WIDTH-1:0]     z,
  output logic [3*LANES-1:0]   status,
  output logic                 pipe_full,
  output logic                 pipe_ovf,
  output logic                 arrive,
  output logic [ID_WIDTH-1:0]  arrive_id,
  output logic                 push_out_n,
  output logic [CW-1:0]        pipe_census
);

  localparam int LW = WIDTH / LANES;

  // Index 0 is S1 (insertion slot), index STAGES-1 is the output slot.
  logic [STAGES-1:0]   v_q;
  logic [WIDTH-1:0]    z_q  [STAGES];
  logic [3*LANES-1:0]  st_q [STAGES];
  logic [ID_WIDTH-1:0] id_q [STAGES];
  logic [CW-1:0]       census_q;
  logic                ovf_q;

  logic [STAGES-1:0]   adv;
  logic                full_after;
  logic                push;
  logic                accept;
  logic [WIDTH-1:0]    calc_z;
  logic [3*LANES-1:0]  calc_st;
  logic [LW:0]         ext_a, ext_b, sum;
  logic [LW-1:0]       res;
  logic                lane_ovf;

  // A valid slot moves when any slot after it is empty or the output is being taken.
  always_comb begin
    adv        = '0;
    full_after = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]     = v_q[k] & (~accept_n | ~full_after);
      full_after = full_after & v_q[k];
    end
  end

  assign push      = v_q[STAGES-1] & ~accept_n;
  assign pipe_full = v_q[0] & ~adv[0];
  assign accept    = launch & (flush | ~pipe_full);

  // One extra bit per lane exposes signed overflow as a disagreement of the top two bits.
  always_comb begin
    calc_z   = '0;
    calc_st  = '0;
    ext_a    = '0;
    ext_b    = '0;
    sum      = '0;
    res      = '0;
    lane_ovf = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      ext_a    = {a[l*LW+LW-1], a[l*LW +: LW]};
      ext_b    = {b[l*LW+LW-1], b[l*LW +: LW]};
      sum      = op ? (ext_a - ext_b) : (ext_a + ext_b);
      lane_ovf = sum[LW] ^ sum[LW-1];
      res      = sum[LW-1:0];
      if ((SAT_MODE != 0) && lane_ovf)
        res = sum[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
      calc_z[l*LW +: LW] = res;
      calc_st[3*l]       = (res == '0);
      calc_st[3*l+1]     = lane_ovf;
      calc_st[3*l+2]     = res[LW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q      <= '0;
      census_q <= '0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        z_q[k]  <= '0;
        st_q[k] <= '0;
        id_q[k] <= '0;
      end
    end else begin
      ovf_q    <= launch & pipe_full & ~flush;
      census_q <= flush ? CW'(accept) : (census_q + CW'(accept) - CW'(push));

      v_q[0] <= ((v_q[0] & ~adv[0]) & ~flush) | accept;
      if (accept || ((OP_ISO_MODE == 0) && !(v_q[0] && !adv[0]))) begin
        z_q[0]  <= calc_z;
        st_q[0] <= calc_st;
        id_q[0] <= launch_id;
      end

      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= ~flush & ((v_q[k] & ~adv[k]) | adv[k-1]);
        if (adv[k-1] || ((OP_ISO_MODE == 0) && !(v_q[k] && !adv[k]))) begin
          z_q[k]  <= z_q[k-1];
          st_q[k] <= st_q[k-1];
          id_q[k] <= id_q[k-1];
        end
      end
    end
  end

  assign arrive      = v_q[STAGES-1];
  assign z           = z_q[STAGES-1];
  assign status      = st_q[STAGES-1];
  assign arrive_id   = id_q[STAGES-1];
  assign push_out_n  = ~push;
  assign pipe_census = census_q;
  assign pipe_ovf    = ovf_q;

endmodule

// File: tb/tb_lp_piped_int_addsub.sv
// tb/tb_lp_piped_int_addsub.sv - self-checking bench for lp_piped_int_addsub
// Three parameterisations share one stimulus; dut0/dut1 are also checked against a queue model.
module tb_lp_piped_int_addsub;

  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a, b;
  logic        op, launch, flush, accept_n;
  logic [7:0]  launch_id;

  logic [31:0] z0, z1;
  logic [7:0]  z2;
  logic [2:0]  st0, st2;
  logic [11:0] st1;
  logic        full0, ovf0, arrive0, push_n0;
  logic        full1, ovf1, arrive1, push_n1;
  logic        full2, ovf2, arrive2, push_n2;
  logic [7:0]  id0, id1, id2;
  logic [2:0]  cen0, cen1, cen2;

  lp_piped_int_addsub dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .launch(launch), .launch_id(launch_id),
    .flush(flush), .accept_n(accept_n), .z(z0), .status(st0), .pipe_full(full0),
    .pipe_ovf(ovf0), .arrive(arrive0), .arrive_id(id0), .push_out_n(push_n0),
    .pipe_census(cen0));

  lp_piped_int_addsub #(.LANES(4), .SAT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .launch(launch), .launch_id(launch_id),
    .flush(flush), .accept_n(accept_n), .z(z1), .status(st1), .pipe_full(full1),
    .pipe_ovf(ovf1), .arrive(arrive1), .arrive_id(id1), .push_out_n(push_n1),
    .pipe_census(cen1));

  lp_piped_int_addsub #(.WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .a(a[7:0]), .b(b[7:0]), .op(op), .launch(launch),
    .launch_id(launch_id), .flush(flush), .accept_n(accept_n), .z(z2), .status(st2),
    .pipe_full(full2), .pipe_ovf(ovf2), .arrive(arrive2), .arrive_id(id2),
    .push_out_n(push_n2), .pipe_census(cen2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          sel;
    logic [31:0] a, b;
    logic        op;
    logic [31:0] ez;
    logic [11:0] es;
  } vec_t;

  typedef struct {
    logic [31:0] z0, z1;
    logic [11:0] st0, st1;
    logic [7:0]  id;
    int          cyc;
  } item_t;

  item_t q[$];
  int    sel;
  logic [31:0] sel_z;
  logic [11:0] sel_st;
  logic [7:0]  sel_id;
  logic        sel_arrive, sel_push_n;

  always_comb begin
    sel_z = z0; sel_st = {9'b0, st0}; sel_id = id0; sel_arrive = arrive0; sel_push_n = push_n0;
    case (sel)
      1: begin sel_z = z1; sel_st = st1; sel_id = id1; sel_arrive = arrive1; sel_push_n = push_n1; end
      2: begin sel_z = {24'b0, z2}; sel_st = {9'b0, st2}; sel_id = id2; sel_arrive = arrive2; sel_push_n = push_n2; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Lane results from signed integer arithmetic and explicit range tests; returns {status, z}.
  function automatic logic [43:0] ref_calc(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic rop, input int lanes, input bit sat);
    int          lw;
    longint      half, full, av, bv, r;
    logic [63:0] ta, tb, acc;
    logic [11:0] st;
    bit          ovf;
    lw   = 32 / lanes;
    half = longint'(1) << (lw - 1);
    full = half * 2;
    acc  = '0;
    st   = '0;
    for (int l = 0; l < lanes; l++) begin
      ta = {32'b0, ra} >> (l * lw);
      tb = {32'b0, rb} >> (l * lw);
      av = longint'(ta) & (full - 1);
      bv = longint'(tb) & (full - 1);
      if (av >= half) av = av - full;
      if (bv >= half) bv = bv - full;
      r   = rop ? av - bv : av + bv;
      ovf = (r >= half) || (r < -half);
      if (ovf) begin
        if (sat) r = (r >= half) ? half - 1 : -half;
        else     r = (r >= half) ? r - full : r + full;
      end
      acc = acc | ((64'(r) & 64'(full - 1)) << (l * lw));
      st[3*l]   = (r == 0);
      st[3*l+1] = ovf;
      st[3*l+2] = (r < 0);
    end
    return {st, acc[31:0]};
  endfunction

  task automatic check_out(input string tag);
    if (arrive0) begin
      if (q.size() == 0) begin
        chk({tag, "_spurious_arrive"}, 1, 0);
      end else begin
        chk({tag, "_z0"}, z0, q[0].z0);
        chk({tag, "_st0"}, st0, q[0].st0[2:0]);
        chk({tag, "_z1"}, z1, q[0].z1);
        chk({tag, "_st1"}, st1, q[0].st1);
        chk({tag, "_id"}, id0, q[0].id);
        chk({tag, "_latency_ok"}, (cyc - q[0].cyc) >= STAGES, 1);
        if (!accept_n) void'(q.pop_front());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  logic [7:0] got[$];
  int n;
  bit exp_full, exp_ovf, acc_l;
  logic [43:0] r0, r1;

  initial begin
    tbl[0] = '{0, 32'd5,        32'd7,        1'b0, 32'd12,       12'h000};
    tbl[1] = '{0, 32'hFFFFFFFF, 32'd1,        1'b0, 32'h00000000, 12'h001};
    tbl[2] = '{0, 32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 12'h006};
    tbl[3] = '{0, 32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 12'h004};
    tbl[4] = '{0, 32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 12'h002};
    tbl[5] = '{1, 32'h7F0180FF, 32'h0101FF01, 1'b0, 32'h7F028000, 12'h431};
    tbl[6] = '{1, 32'h80808080, 32'h01010101, 1'b1, 32'h80808080, 12'hDB6};
    tbl[7] = '{2, 32'h80,       32'h01,       1'b1, 32'h7F,       12'h002};
    tbl[8] = '{2, 32'h7F,       32'h01,       1'b0, 32'h80,       12'h006};
    tbl[9] = '{2, 32'h10,       32'h10,       1'b1, 32'h00,       12'h001};

    a = '0; b = '0; op = 1'b0; launch = 1'b0; flush = 1'b0; accept_n = 1'b0;
    launch_id = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arrive", arrive0, 0);
    chk("rst_push_n", push_n0, 1);
    chk("rst_full", full0, 0);
    chk("rst_census", cen0, 0);
    chk("rst_ovf", ovf0, 0);

    // Table vectors: the first launch coincides with reset release.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sel = tbl[i].sel; a = tbl[i].a; b = tbl[i].b; op = tbl[i].op;
      launch = 1'b1; launch_id = 8'h3C + 8'(i);
      next_cycle();
      launch = 1'b0;
      repeat (STAGES - 2) next_cycle();
      #1 chk("vec_early_arrive", sel_arrive, 0);
      next_cycle();
      #1;
      chk("vec_arrive", sel_arrive, 1);
      chk("vec_z", sel_z, tbl[i].ez);
      chk("vec_status", sel_st, tbl[i].es);
      chk("vec_id", sel_id, 8'h3C + 8'(i));
      chk("vec_push_n", sel_push_n, 0);
      next_cycle();
    end
    sel = 0;

    // Back-pressure: fill, drop a launch, then drain in order.
    accept_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      launch = 1'b1; launch_id = 8'(i + 1); a = i; b = 0; op = 1'b0;
      #1 chk("bp_full", full0, (i == 4));
      if (i == 4) chk("bp_census4", cen0, 4);
      next_cycle();
    end
    launch = 1'b0;
    chk("bp_ovf_pulse", ovf0, 1);
    chk("bp_census_hold", cen0, 4);
    accept_n = 1'b0;
    got.delete();
    for (int t = 0; t < 12 && got.size() < 4; t++) begin
      #1;
      if (t == 1) chk("bp_ovf_cleared", ovf0, 0);
      if (arrive0 && !push_n0) got.push_back(id0);
      next_cycle();
    end
    chk("bp_drain_count", got.size(), 4);
    for (int j = 0; j < got.size(); j++) chk("bp_order", got[j], 8'(j + 1));
    next_cycle();
    chk("bp_census_empty", cen0, 0);

    // Flush with simultaneous launch.
    for (int i = 0; i < 3; i++) begin
      launch = 1'b1; launch_id = 8'hA1 + 8'(i);
      next_cycle();
    end
    flush = 1'b1; launch = 1'b1; launch_id = 8'h11;
    next_cycle();
    flush = 1'b0; launch = 1'b0;
    chk("flush_census", cen0, 1);
    chk("flush_no_ovf", ovf0, 0);
    n = 0;
    for (int t = 1; t <= 8; t++) begin
      #1;
      if (arrive0) begin
        n++;
        chk("flush_arrive_id", id0, 8'h11);
        chk("flush_arrive_cycle", t, STAGES);
      end
      next_cycle();
    end
    chk("flush_arrive_count", n, 1);

    // Reset mid-stream, relaunch on the first edge after release.
    for (int i = 0; i < 2; i++) begin
      launch = 1'b1; launch_id = 8'hB0 + 8'(i);
      next_cycle();
    end
    launch = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_arrive", arrive0, 0);
    chk("mid_rst_census", cen0, 0);
    chk("mid_rst_push_n", push_n0, 1);
    chk("mid_rst_full", full0, 0);
    next_cycle();
    rst = 1'b0; launch = 1'b1; launch_id = 8'h55;
    next_cycle();
    launch = 1'b0;
    n = 0;
    for (int t = 1; t <= 8; t++) begin
      #1;
      if (arrive0) begin
        n++;
        chk("post_rst_id", id0, 8'h55);
        chk("post_rst_cycle", t, STAGES);
      end
      next_cycle();
    end
    chk("post_rst_arrive_count", n, 1);

    // Randomized traffic against the queue model.
    q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < 400; k++) begin
      launch    = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      accept_n  = ($urandom_range(0, 9) < 3);
      a = $urandom; b = $urandom; op = 1'($urandom);
      launch_id = 8'($urandom);
      #1;
      exp_full = (q.size() == STAGES) && accept_n;
      chk("rnd_census", cen0, q.size());
      chk("rnd_ovf", ovf0, exp_ovf);
      chk("rnd_full", full0, exp_full);
      check_out("rnd");
      acc_l = launch && (!exp_full || flush);
      if (flush) q.delete();
      if (acc_l) begin
        r0 = ref_calc(a, b, op, 1, 1'b0);
        r1 = ref_calc(a, b, op, 4, 1'b1);
        q.push_back('{r0[31:0], r1[31:0], r0[43:32], r1[43:32], launch_id, cyc});
      end
      exp_ovf = launch && exp_full && !flush;
      next_cycle();
    end
    launch = 1'b0; flush = 1'b0; accept_n = 1'b0;
    for (int t = 0; t < 40 && q.size() > 0; t++) begin
      #1;
      check_out("drain");
      next_cycle();
    end
    chk("rnd_drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lp_piped_int_addsub.md
LP_PIPED_INT_ADDSUB -- requirements
Module: lp_piped_int_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, total operand width; legal 8..64, multiple of LANES.
REQ-002 SHALL have parameter LANES, default 1, independent SIMD lanes of LW=WIDTH/LANES bits; legal 1, 2, 4.
REQ-003 SHALL have parameter SAT_MODE, default 0, where 0 means two's-complement wrap and 1 means signed saturation per lane.
REQ-004 SHALL have parameter ID_WIDTH, default 8, launch/arrive tag width; legal 1..16.
REQ-005 SHALL have parameter STAGES, default 4, pipeline slots; legal 1..8; CW=$clog2(STAGES+1).
REQ-006 SHALL have parameter OP_ISO_MODE, default 1, where 1 means stage-1 operand registers hold value when no launch is accepted.
REQ-007 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  1  0 = a+b, 1 = a-b (all lanes).
- launch  in  1  insert request.
- launch_id  in  ID_WIDTH  tag for the inserted operation.
- flush  in  1  discard pipeline contents.
- accept_n  in  1  active-low downstream accept.
- z  out  WIDTH  result of the output slot.
- status  out  3*LANES  per lane l: bit 3l = zero, bit 3l+1 = overflow/saturated, bit 3l+2 = negative.
- pipe_full  out  1  insert not possible this cycle.
- pipe_ovf  out  1  one-cycle pulse: launch was dropped.
- arrive  out  1  output slot valid.
- arrive_id  out  ID_WIDTH  tag of the output slot.
- push_out_n  out  1  active-low; result handed off this cycle.
- pipe_census  out  CW  count of valid slots.

Function
REQ-008 SHALL hold STAGES slots S1..SSTAGES, each containing valid, z, status and id; SSTAGES is the output slot.
REQ-009 SHALL compute the per-lane signed sum or difference at insertion into S1; later slots only transport data.
REQ-010 SHALL, with SAT_MODE=0, wrap each lane modulo 2^LW and set the overflow bit on signed overflow.
REQ-011 SHALL, with SAT_MODE=1, clamp an overflowing lane to +2^(LW-1)-1 or -2^(LW-1) and set that lane's overflow bit.
REQ-012 SHALL derive the zero and negative bits from the final lane result, after any saturation.
REQ-013 SHALL advance slot k when slot k+1 is empty or advancing; advancement collapses bubbles.
REQ-014 SHALL advance the output slot when arrive=1 and accept_n=0.
REQ-015 SHALL drive arrive = SSTAGES.valid, z/status/arrive_id = SSTAGES contents, and push_out_n = ~(arrive & ~accept_n), all combinational from state and accept_n.
REQ-016 SHALL accept a launch when S1 is empty or advancing; pipe_full = S1.valid & ~S1-advance, combinational.
REQ-017 SHALL give latency STAGES: a launch accepted in cycle c with no stall yields arrive=1 in cycle c+STAGES.
REQ-018 SHALL, when launch=1 and pipe_full=1, drop the operation, leave state unchanged and pulse pipe_ovf registered for exactly the next cycle.
REQ-019 SHALL, when flush=1, clear all valid bits at the next edge.
REQ-020 SHALL, when flush=1 and launch=1 in the same cycle, keep the launch: after the edge, census=1 and S1 holds the new operation.
REQ-021 SHALL NOT drop a launch while flush=1; pipe_ovf=0 in that case.
REQ-022 SHALL update pipe_census registered each edge as (previous count) + (accepted insert) - (push).
REQ-023 SHALL never let pipe_census exceed STAGES or go below 0.
REQ-024 SHALL leave z, status and arrive_id don't-care while arrive=0; the bench checks them only while arrive=1.
REQ-025 SHALL, with OP_ISO_MODE=1, leave datapath registers unchanged in slots that do not receive new data.

Reset
REQ-026 SHALL, on rst=1 asynchronously, clear all valid bits, pipe_census, pipe_ovf and all data registers to 0.
REQ-027 SHALL hold these reset values while rst=1: arrive=0, push_out_n=1, pipe_full=0.
REQ-028 SHALL discard in-flight operations on mid-operation reset and emit no arrive after rst deasserts.
REQ-029 SHALL accept a launch on the first edge after rst deasserts.

Verification
REQ-030 SHALL cover this basic case: WIDTH=32, LANES=1, STAGES=4; a=5, b=7, op=0, id=0x3C launched in cycle 0 with accept_n=0 -> arrive=1 in cycle 4, z=12, arrive_id=0x3C, push_out_n=0, status=000.
REQ-031 SHALL cover saturation: SAT_MODE=1, LANES=4, a=0x7F01_80FF, b=0x0101_FF01, op=0 -> lanes: 0x7F, 0x02, 0x80 (saturated), 0x00; overflow on lanes 3 and 1, zero on lane 0.
REQ-032 SHALL cover back-pressure: accept_n=1, launch every cycle from cycle 0 -> census reaches 4 and pipe_full=1 in cycle 4; the launch in cycle 4 is dropped and pipe_ovf=1 in cycle 5; on accept_n=0 the four results drain in launch order.
REQ-033 SHALL cover flush with launch: 3 items in flight, flush=1 with launch (id=0x11) in the same cycle -> census=1 next cycle; the only arrive is id 0x11, after STAGES cycles.
REQ-034 SHALL cover reset mid-stream: 2 items in flight, rst pulsed for 1 cycle -> arrive=0, census=0, no later arrive; the first launch afterwards completes with latency 4.
REQ-035 SHALL cover subtraction wrap: SAT_MODE=0, LANES=1, WIDTH=8, a=0x80, b=0x01, op=1 -> z=0x7F, overflow=1, negative=0.
